// File: rtl/keypad_pkg.sv
// Shared types and key legend for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_ENTER = 4'hC;

    // '*' reads as E and '#' as F on the bottom row
    function automatic logic [3:0] legend(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks.
module ms_tick_gen #(
    parameter int SCAN_DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (div == DIV_W'(SCAN_DIV - 1))
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end

    assign tick = (div == DIV_W'(SCAN_DIV - 1));

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and 6-digit BCD entry register.
// Optional auto-repeat of digit/backspace keys when KEY_REPEAT_EN is defined.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 50_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [23:0] num,
    output logic        num_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

    // The repeat reload value is REPEAT_DLY-REPEAT_RATE, so the rate may not exceed the delay
    if (DEBOUNCE_MS < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DLY) begin : g_bad_cfg
        $error("keypad_entry: invalid timing parameters");
    end

    function automatic logic [1:0] low_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--)
            if (!r[i]) idx = 2'(i);
        return idx;
    endfunction

    function automatic logic [1:0] col_idx(input logic [3:0] c);
        case (c)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    endfunction

    logic             tick;
    logic [3:0]       rs_p0, rs;
    state_t           state;
    logic [3:0]       cap;
    logic [CNT_W-1:0] cnt, rcnt;
    logic             vld_p0;
    logic [3:0]       code_p0;
    logic             accept;
    logic [3:0]       col_rot;

    ms_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Stage p0: row synchronizer, idles at "no key" so reset never fakes a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_p0 <= 4'hF;
            rs    <= 4'hF;
        end else begin
            rs_p0 <= row;
            rs    <= rs_p0;
        end
    end

    assign accept  = tick && (state == DEBOUNCE) && (rs == cap) && (cnt == CNT_W'(DEBOUNCE_MS - 1));
    assign col_rot = {col[2:0], col[3]};

    always_ff @(posedge clk) begin
        if (accept)
            code_p0 <= legend(low_row(cap), col_idx(col));
    end

`ifdef KEY_REPEAT_EN
    localparam int HLD_W = $clog2(REPEAT_DLY + 1);
    logic [HLD_W-1:0] hcnt;
    logic             rpt_key;

    assign rpt_key = (code_p0 <= 4'd9) || (code_p0 == KEY_BKSP);
`endif

    // Stage p1: scan FSM, advances only on tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SCAN;
            col    <= 4'b1110;
            cap    <= 4'hF;
            cnt    <= '0;
            rcnt   <= '0;
            vld_p0 <= 1'b0;
`ifdef KEY_REPEAT_EN
            hcnt   <= '0;
`endif
        end else begin
            vld_p0 <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (rs == 4'hF) begin
                            col <= col_rot;
                        end else begin
                            cap   <= rs;
                            cnt   <= CNT_W'(1);
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (rs != cap) begin
                            state <= SCAN;
                            col   <= col_rot;
                            cnt   <= '0;
                        end else if (accept) begin
                            state  <= PRESSED;
                            cnt    <= '0;
                            rcnt   <= '0;
                            vld_p0 <= 1'b1;
`ifdef KEY_REPEAT_EN
                            hcnt   <= '0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (rs == 4'hF) begin
                            if (rcnt == CNT_W'(DEBOUNCE_MS - 1)) begin
                                state <= SCAN;
                                col   <= col_rot;
                                rcnt  <= '0;
                            end else begin
                                rcnt <= rcnt + CNT_W'(1);
                            end
                        end else begin
                            rcnt <= '0;
                        end
`ifdef KEY_REPEAT_EN
                        if (rs == cap && rpt_key) begin
                            if (hcnt == HLD_W'(REPEAT_DLY - 1)) begin
                                vld_p0 <= 1'b1;
                                hcnt   <= HLD_W'(REPEAT_DLY - REPEAT_RATE);
                            end else begin
                                hcnt <= hcnt + HLD_W'(1);
                            end
                        end else begin
                            hcnt <= '0;
                        end
`endif
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    // Stage p2: event outputs and BCD entry register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            num       <= 24'h0;
            num_valid <= 1'b0;
        end else begin
            key_valid <= vld_p0;
            num_valid <= vld_p0 && (code_p0 == KEY_ENTER);
            if (vld_p0) begin
                key_code <= code_p0;
                if (code_p0 <= 4'd9)
                    num <= {num[19:0], code_p0};
                else if (code_p0 == KEY_BKSP)
                    num <= {4'h0, num[23:4]};
                else if (code_p0 == KEY_CLR)
                    num <= 24'h0;
            end
        end
    end

endmodule
